// File: rtl/memory_dumper_if.sv
// Bus between memory_dumper, the sample memory read port and the UART tx.
interface memory_dumper_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] oAddress;
  logic [15:0]           iData;
  logic [7:0]            oTxData;
  logic                  oTxValid;
  logic                  iTxReady;

  modport master (
    output oAddress,
    output oTxData,
    output oTxValid,
    input  iData,
    input  iTxReady
  );

  modport slave (
    input  oAddress,
    input  oTxData,
    input  oTxValid,
    output iData,
    output iTxReady
  );
endinterface

// File: rtl/memory_dumper.sv
// Walks sample memory 0..LAST_ADDR and streams each word MSB byte first.
// Optional leading 8'hA5 byte: define MEMORY_DUMPER_HEADER_EN.
module memory_dumper #(
  parameter int unsigned          ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR   = 16'hFFFF,
  parameter int unsigned          READ_LATENCY = 1
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iStartSignal,
  memory_dumper_if.master  bus,
  output logic             oBusy,
  output logic             oFinished
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_SEND_HI = 3'd2;
  localparam logic [2:0] S_SEND_LO = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
`ifdef MEMORY_DUMPER_HEADER_EN
  localparam logic [2:0] S_HEADER  = 3'd5;
  localparam logic [7:0] HDR_BYTE  = 8'hA5;
`endif

  localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [2:0]            cnt_q,   cnt_d;
  logic [15:0]           word_q,  word_d;
  logic [7:0]            txd_q,   txd_d;
  logic                  txv_q,   txv_d;
  logic                  xfer;

  assign xfer = txv_q & bus.iTxReady;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        addr_d = '0;
        cnt_d  = '0;
        if (iStartSignal) begin
`ifdef MEMORY_DUMPER_HEADER_EN
          state_d = S_HEADER;
          txd_d   = HDR_BYTE;
          txv_d   = 1'b1;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef MEMORY_DUMPER_HEADER_EN
      (state_q == S_HEADER): begin
        if (xfer) begin
          txv_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
`endif
      (state_q == S_FETCH): begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          word_d  = bus.iData;
          txd_d   = bus.iData[15:8];
          txv_d   = 1'b1;
          state_d = S_SEND_HI;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      (state_q == S_SEND_HI): begin
        if (xfer) begin
          // rotate so the byte still owed sits in the upper half
          txd_d   = word_q[7:0];
          word_d  = {word_q[7:0], word_q[15:8]};
          state_d = S_SEND_LO;
        end
      end
      (state_q == S_SEND_LO): begin
        if (xfer) begin
          txv_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      (state_q == S_DONE): begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        cnt_d   = '0;
        txv_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
    end
  end

  assign bus.oAddress = addr_q;
  assign bus.oTxData  = txd_q;
  assign bus.oTxValid = txv_q;
  assign oBusy        = (state_q != S_IDLE);
  assign oFinished    = (state_q == S_DONE);

endmodule

// File: tb/tb_memory_dumper.sv
// Scoreboard bench: 4-word dump (latency 1) and 1-word dump (latency 3).
module tb_memory_dumper;

`ifdef MEMORY_DUMPER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic startA, startB;
  logic busyA, busyB, finishA, finishB;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   finA = 0, finB = 0;
  int   finA_cyc = 0;
  int   cS;
  logic [7:0] qA[$];
  logic [7:0] qB[$];
  logic       stallA = 1'b0, stallB = 1'b0;
  logic [7:0] lastA, lastB;
  logic [15:0] pB1 = 16'hDEAD, pB2 = 16'hBEEF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_dumper_if #(.ADDR_WIDTH(16)) busA ();
  memory_dumper_if #(.ADDR_WIDTH(16)) busB ();

  memory_dumper #(
    .ADDR_WIDTH(16), .LAST_ADDR(16'd3), .READ_LATENCY(1)
  ) dutA (
    .iClock(clk), .iReset(rst), .iStartSignal(startA),
    .bus(busA), .oBusy(busyA), .oFinished(finishA)
  );

  memory_dumper #(
    .ADDR_WIDTH(16), .LAST_ADDR(16'd0), .READ_LATENCY(3)
  ) dutB (
    .iClock(clk), .iReset(rst), .iStartSignal(startB),
    .bus(busB), .oBusy(busyB), .oFinished(finishB)
  );

  function automatic logic [15:0] memA(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h1234;
      16'd1:   return 16'hABCD;
      16'd2:   return 16'h0000;
      16'd3:   return 16'hFFFF;
      default: return 16'hBAD0;
    endcase
  endfunction

  assign busA.iData = memA(busA.oAddress);

  // memory B answers through two registers: data valid 3 cycles after address
  always @(posedge clk) begin
    pB1 <= (busB.oAddress == 16'd0) ? 16'h5AC3 : 16'hBAD1;
    pB2 <= pB1;
  end
  assign busB.iData = pB2;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_A();
    if (HDR != 0) qA.push_back(8'hA5);
    qA.push_back(8'h12); qA.push_back(8'h34);
    qA.push_back(8'hAB); qA.push_back(8'hCD);
    qA.push_back(8'h00); qA.push_back(8'h00);
    qA.push_back(8'hFF); qA.push_back(8'hFF);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stallA = 1'b0;
      stallB = 1'b0;
    end else begin
      if (stallA) begin
        check("A_hold_valid", {31'd0, busA.oTxValid}, 32'd1);
        check("A_hold_data", {24'd0, busA.oTxData}, {24'd0, lastA});
      end
      if (busA.oTxValid && busA.iTxReady) begin
        check("A_expected_byte", {31'd0, qA.size() != 0}, 32'd1);
        if (qA.size() != 0)
          check("A_byte", {24'd0, busA.oTxData}, {24'd0, qA.pop_front()});
      end
      stallA = busA.oTxValid && !busA.iTxReady;
      lastA  = busA.oTxData;
      if (finishA) begin
        finA++;
        finA_cyc = cyc;
      end
      if (stallB) begin
        check("B_hold_data", {24'd0, busB.oTxData}, {24'd0, lastB});
      end
      if (busB.oTxValid && busB.iTxReady) begin
        check("B_expected_byte", {31'd0, qB.size() != 0}, 32'd1);
        if (qB.size() != 0)
          check("B_byte", {24'd0, busB.oTxData}, {24'd0, qB.pop_front()});
      end
      stallB = busB.oTxValid && !busB.iTxReady;
      lastB  = busB.oTxData;
      if (finishB) finB++;
    end
  end

  initial begin
    rst = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    busA.iTxReady = 1'b1;
    busB.iTxReady = 1'b1;
    step(2);
    check("rst_A_addr", {16'd0, busA.oAddress}, 32'd0);
    check("rst_A_valid", {31'd0, busA.oTxValid}, 32'd0);
    check("rst_A_data", {24'd0, busA.oTxData}, 32'd0);
    check("rst_A_busy", {31'd0, busyA}, 32'd0);
    check("rst_A_fin", {31'd0, finishA}, 32'd0);
    check("rst_B_addr", {16'd0, busB.oAddress}, 32'd0);
    check("rst_B_valid", {31'd0, busB.oTxValid}, 32'd0);
    check("rst_B_busy", {31'd0, busyB}, 32'd0);
    rst = 1'b0;
    step(2);

    // full dump, ready high, exact cycle of finished pulse
    push_A();
    startA = 1'b1;
    step(1);
    cS = cyc;
    startA = 1'b0;
    check("T1_busy", {31'd0, busyA}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      if (finA == 1) break;
      step(1);
    end
    check("T1_fin_count", finA, 1);
    check("T1_fin_cycle", finA_cyc - cS, 12 + HDR);
    check("T1_queue_empty", qA.size(), 0);
    step(1);
    check("T1_addr_back", {16'd0, busA.oAddress}, 32'd0);
    check("T1_idle", {31'd0, busyA}, 32'd0);

    // same dump with random back-pressure
    push_A();
    startA = 1'b1;
    step(1);
    startA = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (finA == 2) break;
      busA.iTxReady = 1'($urandom_range(0, 1));
      step(1);
    end
    busA.iTxReady = 1'b1;
    check("T2_fin_count", finA, 2);
    check("T2_queue_empty", qA.size(), 0);
    step(1);
    check("T2_addr_back", {16'd0, busA.oAddress}, 32'd0);

    // starts in SEND_LO and in DONE are ignored
    push_A();
    startA = 1'b1;
    step(1);
    startA = 1'b0;
    step(2 + HDR);
    startA = 1'b1;
    step(1);
    startA = 1'b0;
    step(9);
    check("T3_done_fin", {31'd0, finishA}, 32'd1);
    check("T3_done_busy", {31'd0, busyA}, 32'd1);
    startA = 1'b1;
    step(1);
    startA = 1'b0;
    check("T3_idle_after_done", {31'd0, busyA}, 32'd0);
    step(4);
    check("T3_still_idle", {31'd0, busyA}, 32'd0);
    check("T3_fin_count", finA, 3);
    check("T3_queue_empty", qA.size(), 0);

    // reset while word 1 HI byte waits on ready
    if (HDR != 0) qA.push_back(8'hA5);
    qA.push_back(8'h12); qA.push_back(8'h34); qA.push_back(8'hAB);
    startA = 1'b1;
    step(1);
    startA = 1'b0;
    step(4 + HDR);
    busA.iTxReady = 1'b0;
    step(3);
    check("T4_wait_valid", {31'd0, busA.oTxValid}, 32'd1);
    check("T4_wait_data", {24'd0, busA.oTxData}, 32'hAB);
    check("T4_wait_addr", {16'd0, busA.oAddress}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("T4_rst_valid", {31'd0, busA.oTxValid}, 32'd0);
    check("T4_rst_addr", {16'd0, busA.oAddress}, 32'd0);
    check("T4_rst_data", {24'd0, busA.oTxData}, 32'd0);
    check("T4_rst_busy", {31'd0, busyA}, 32'd0);
    qA.delete();
    step(1);
    rst = 1'b0;
    busA.iTxReady = 1'b1;
    step(3);
    check("T4_no_fin", finA, 3);
    check("T4_idle", {31'd0, busyA}, 32'd0);

    // fresh dump after reset starts at address 0
    push_A();
    startA = 1'b1;
    step(1);
    startA = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (finA == 4) break;
      step(1);
    end
    check("T5_fin_count", finA, 4);
    check("T5_queue_empty", qA.size(), 0);

    // one-word dump, read latency 3
    if (HDR != 0) qB.push_back(8'hA5);
    qB.push_back(8'h5A);
    qB.push_back(8'hC3);
    startB = 1'b1;
    step(1);
    startB = 1'b0;
    step(2 + HDR);
    check("T6_valid_early", {31'd0, busB.oTxValid}, 32'd0);
    step(1);
    check("T6_first_valid", {31'd0, busB.oTxValid}, 32'd1);
    check("T6_first_data", {24'd0, busB.oTxData}, 32'h5A);
    for (int i = 0; i < 50; i++) begin
      if (finB == 1) break;
      step(1);
    end
    check("T6_fin_count", finB, 1);
    check("T6_queue_empty", qB.size(), 0);
    step(3);
    check("T6_idle", {31'd0, busyB}, 32'd0);
    check("T6_single_fin", finB, 1);
    check("T6_addr_back", {16'd0, busB.oAddress}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_dumper.md
# memory_dumper

Read-side counterpart of the capture sampler in the RS-232 test design. On a start pulse it walks the sample memory from address 0 to `LAST_ADDR` and reads each word. It splits each word into bytes, MSB first, and hands them to the UART transmitter over a valid/ready handshake. When the last byte of the last word has been accepted, it pulses a finished flag.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, memory address width
- `LAST_ADDR`, 16'hFFFF, final address dumped (inclusive); must be < 2^ADDR_WIDTH
- `READ_LATENCY`, 1, cycles from `oAddress` change to valid `iData` (1..7)

Ports:
- `iClock`  in  1  clock; all state on rising edge
- `iReset`  in  1  reset, asynchronous, active-high
- `iStartSignal`  in  1  start request; sampled only in IDLE
- `oAddress`  out  ADDR_WIDTH  memory read address
- `iData`  in  16  memory read data
- `oTxData`  out  8  byte to transmitter
- `oTxValid`  out  1  `oTxData` valid
- `iTxReady`  in  1  transmitter can accept a byte
- `oBusy`  out  1  high in every state except IDLE
- `oFinished`  out  1  one-cycle pulse at end of dump

## Operation
- Reset values: state IDLE, `oAddress`=0, `oTxData`=0, `oTxValid`=0, `oBusy`=0, `oFinished`=0, latency counter 0, word register 0.
- States: IDLE, FETCH, SEND_HI, SEND_LO, DONE (HEADER only with the macro).
- IDLE -> FETCH when `iStartSignal`=1 (HEADER instead if enabled). `oAddress` is held at 0.
- FETCH: counts `READ_LATENCY` cycles with `oAddress` stable. On the last count it latches `iData` into the word register, loads `oTxData`=word[15:8], sets `oTxValid`, then moves to SEND_HI.
- SEND_HI: on an edge with `oTxValid`&`iTxReady`, loads `oTxData`=word[7:0] and keeps `oTxValid`=1, then moves to SEND_LO.
- SEND_LO: on a transfer edge, drops `oTxValid`.
  - If `oAddress`==`LAST_ADDR` -> DONE.
  - Else `oAddress`+1 -> FETCH.
- DONE: `oFinished`=1 for exactly this cycle, `oAddress`<=0, then -> IDLE.
- Handshake rules:
  - A transfer occurs on a rising edge where `oTxValid`=1 and `iTxReady`=1.
  - Once asserted, `oTxValid` and `oTxData` stay stable until that transfer.
  - `iTxReady` may toggle arbitrarily; it has no effect while `oTxValid`=0.
- `iStartSignal` is ignored outside IDLE. A start in the same cycle as the DONE->IDLE transition is ignored; only starts sampled while in IDLE count.
- Address arithmetic: unsigned, ADDR_WIDTH bits. Compare-to-`LAST_ADDR` precedes the increment, so no wrap occurs. `LAST_ADDR`=0 dumps exactly one word.
- Reset mid-operation (any state, including mid-handshake): outputs return to reset values immediately; the partial dump is abandoned and no `oFinished` is produced.

## Timing
- Start to first `oTxValid`: 1 (enter FETCH) + `READ_LATENCY` cycles (header disabled).
- Per word, with `iTxReady` tied high: `READ_LATENCY` + 2 cycles.
- HI and LO bytes are back-to-back (no valid gap). Between words, `oTxValid` is low for `READ_LATENCY` cycles.
- Full default dump with ready tied high and `READ_LATENCY`=1: 65536*3 cycles from first FETCH to DONE.
- `oFinished` rises the cycle after the final transfer edge.

## Configuration
- `MEMORY_DUMPER_HEADER_EN` defined:
  - IDLE -> HEADER on start.
  - HEADER presents `oTxData`=8'hA5 with `oTxValid`=1, and moves to FETCH after it transfers (`oAddress` still 0).
  - Adds 1 byte and 1+ cycles to the dump.
- Not defined: the HEADER state and its logic are absent; the byte stream is data only.

## Test plan
- `LAST_ADDR`=3, memory holds 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF at addresses 0..3, ready tied high, start pulse -> bytes 12,34,AB,CD,00,00,FF,FF in order; one `oFinished` pulse; `oAddress` returns to 0.
- Same setup, `iTxReady` toggled pseudo-randomly -> identical byte sequence; `oTxData` never changes while valid and not ready.
- `LAST_ADDR`=0, start -> exactly two bytes, then `oFinished`. `READ_LATENCY`=3 -> first valid at start+4 cycles.
- Start pulses during SEND_LO and during DONE -> ignored; exactly one dump and one `oFinished`.
- `iReset` asserted while SEND_HI is waiting on ready -> `oTxValid`=0 and `oAddress`=0 immediately, no `oFinished`; a new start afterwards dumps from address 0.
- With `MEMORY_DUMPER_HEADER_EN`, `LAST_ADDR`=1 -> bytes A5, then the four data bytes; without the macro, no A5.
